// File: rtl/cmd_decoder_pkg.sv
// cmd_decoder_pkg: shared types and constants for the command decoder.
//   state_t     - FSM state encoding (IDLE, ARGS, DISPATCH, WAIT)
//   VERB_*      - verb byte values accepted from the mbed link
//   RESP_*      - response codes reported back to the mbed
//   verb_nargs  - number of argument bytes that follow a verb
//   verb_chan   - subsystem channel addressed by a verb
package cmd_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARGS     = 2'd1,
    ST_DISPATCH = 2'd2,
    ST_WAIT     = 2'd3
  } state_t;

  localparam logic [7:0] VERB_RESET = 8'h01;
  localparam logic [7:0] VERB_PING  = 8'h02;
  localparam logic [7:0] VERB_CTRL  = 8'h03;
  localparam logic [7:0] VERB_SOUND = 8'h04;
  localparam logic [7:0] VERB_ANIM  = 8'h05;
  localparam logic [7:0] VERB_TOKEN = 8'h06;

  localparam logic [7:0] RESP_RESET_ACK = 8'h01;
  localparam logic [7:0] RESP_ERROR     = 8'h02;
  localparam logic [7:0] RESP_SUCCESS   = 8'h03;
  localparam logic [7:0] RESP_START_ACK = 8'h04;
  localparam logic [7:0] RESP_PING_ACK  = 8'h05;

  function automatic int unsigned verb_nargs(input logic [7:0] verb);
    case (verb)
      VERB_CTRL:  return 2;
      VERB_SOUND: return 1;
      VERB_ANIM:  return 1;
      VERB_TOKEN: return 3;
      default:    return 0;
    endcase
  endfunction

  function automatic int unsigned verb_chan(input logic [7:0] verb);
    case (verb)
      VERB_CTRL:  return 0;
      VERB_SOUND: return 1;
      VERB_ANIM:  return 2;
      VERB_TOKEN: return 3;
      default:    return 0;
    endcase
  endfunction

endpackage

// File: rtl/cmd_decoder_link_rx.sv
// link_rx: receive side of the level-signalled mbed byte link.
//   clk, rst_n  - clock, asynchronous active-low reset
//   data        - link byte from the mbed
//   data_ready  - asynchronous level; each 0->1 transition presents one byte
//   byte_data   - latched byte, valid while byte_valid is high
//   byte_valid  - one-cycle strobe, one per data_ready rising edge
// data_ready passes through two synchroniser flops; a third flop holds the
// previous synchronised value for edge detection. The byte register loads on
// the same clock edge that raises the synchronised copy, so byte_data is
// already settled in the cycle byte_valid is high.
module link_rx #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data,
  input  logic              data_ready,
  output logic [DATA_W-1:0] byte_data,
  output logic              byte_valid
);

  logic sync1, sync2, sync3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync3     <= 1'b0;
      byte_data <= '0;
    end else begin
      sync1 <= data_ready;
      sync2 <= sync1;
      sync3 <= sync2;
      // sync1 & ~sync2 means sync2 rises on this edge: capture the byte now.
      if (sync1 && !sync2) byte_data <= data;
    end
  end

  // Driven only by flops, so no input-to-output combinational path.
  assign byte_valid = sync2 && !sync3;

endmodule

// File: rtl/cmd_decoder.sv
// cmd_decoder: decodes verb/argument bytes from the mbed link, dispatches
// a start pulse to one of N_SUB cabinet subsystems and reports a response.
//   clk, rst_n  - clock, asynchronous active-low reset
//   data        - link byte
//   data_ready  - link level, one byte per rising edge
//   sub_done    - per-channel completion strobes
//   sub_err     - per-channel error strobes
//   start       - one-hot, one-cycle start pulse (registered)
//   args        - argument bank, arg0 in the LSBs (registered)
//   response    - last response code, held until the next one (registered)
//   resp_valid  - one-cycle strobe when response updates
//   busy        - high in every state except IDLE
//   state_dbg   - current FSM state, for observation
// Handshake: each byte is a single accept event (byte_valid); there is no
// back-pressure, bytes arriving in WAIT other than RESET are dropped.
// Requires DATA_W >= 8, MAX_ARGS >= 3, TIMEOUT >= 2, N_SUB >= 2.
module cmd_decoder
  import cmd_decoder_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int MAX_ARGS = 3,
  parameter int TIMEOUT  = 1024,
  parameter int N_SUB    = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_W-1:0]          data,
  input  logic                       data_ready,
  input  logic [N_SUB-1:0]           sub_done,
  input  logic [N_SUB-1:0]           sub_err,
  output logic [N_SUB-1:0]           start,
  output logic [MAX_ARGS*DATA_W-1:0] args,
  output logic [7:0]                 response,
  output logic                       resp_valid,
  output logic                       busy,
  output logic [1:0]                 state_dbg
);

  localparam int IW = $clog2(MAX_ARGS + 1);
  localparam int CW = $clog2(N_SUB);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [DATA_W-1:0] byte_data;
  logic              byte_valid;

  link_rx #(.DATA_W(DATA_W)) u_link_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .data       (data),
    .data_ready (data_ready),
    .byte_data  (byte_data),
    .byte_valid (byte_valid)
  );

  // Verbs are 8-bit codes; on a wider link any set upper bit makes the
  // byte an unknown verb.
  logic [7:0] code;
  logic       code_ok;
  assign code = byte_data[7:0];

  generate
    if (DATA_W > 8) begin : g_wide
      assign code_ok = ~|byte_data[DATA_W-1:8];
    end else begin : g_narrow
      assign code_ok = 1'b1;
    end
  endgenerate

  logic is_abort;
  assign is_abort = byte_valid && code_ok && (code == VERB_RESET);

  state_t                           state;
  logic [7:0]                       verb_q;
  logic [CW-1:0]                    chan_q;
  logic [IW-1:0]                    arg_idx;
  logic [IW-1:0]                    arg_last;
  logic [TW-1:0]                    tcount;
  logic [MAX_ARGS-1:0][DATA_W-1:0]  bank;

  assign arg_last = IW'(verb_nargs(verb_q) - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      verb_q     <= '0;
      chan_q     <= '0;
      arg_idx    <= '0;
      tcount     <= '0;
      bank       <= '0;
      start      <= '0;
      response   <= '0;
      resp_valid <= 1'b0;
    end else begin
      start      <= '0;
      resp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (byte_valid) begin
            resp_valid <= 1'b1;
            if (!code_ok) begin
              response <= RESP_ERROR;
            end else begin
              case (code)
                VERB_RESET: begin
                  bank     <= '0;
                  response <= RESP_RESET_ACK;
                end
                VERB_PING: response <= RESP_PING_ACK;
                VERB_CTRL, VERB_SOUND, VERB_ANIM, VERB_TOKEN: begin
                  verb_q   <= code;
                  chan_q   <= CW'(verb_chan(code));
                  bank     <= '0;
                  arg_idx  <= '0;
                  response <= RESP_START_ACK;
                  state    <= ST_ARGS;
                end
                default: response <= RESP_ERROR;
              endcase
            end
          end
        end

        ST_ARGS: begin
          if (is_abort) begin
            bank       <= '0;
            arg_idx    <= '0;
            response   <= RESP_RESET_ACK;
            resp_valid <= 1'b1;
            state      <= ST_IDLE;
          end else if (byte_valid) begin
            bank[arg_idx] <= byte_data;
            if (arg_idx == arg_last) begin
              arg_idx        <= '0;
              tcount         <= '0;
              start[chan_q]  <= 1'b1;
              state          <= ST_DISPATCH;
            end else begin
              arg_idx <= arg_idx + 1'b1;
            end
          end
        end

        ST_DISPATCH: begin
          // Counting already in DISPATCH makes tcount equal the number of
          // cycles since DISPATCH, so TIMEOUT-1 reports exactly TIMEOUT
          // cycles after the start pulse.
          tcount <= tcount + 1'b1;
          state  <= ST_WAIT;
        end

        ST_WAIT: begin
          tcount <= tcount + 1'b1;
          if (is_abort) begin
            bank       <= '0;
            response   <= RESP_RESET_ACK;
            resp_valid <= 1'b1;
            state      <= ST_IDLE;
          end else if (sub_err[chan_q]) begin
            response   <= RESP_ERROR;
            resp_valid <= 1'b1;
            state      <= ST_IDLE;
          end else if (sub_done[chan_q]) begin
            response   <= RESP_SUCCESS;
            resp_valid <= 1'b1;
            state      <= ST_IDLE;
          end else if (tcount == TW'(TIMEOUT - 1)) begin
            response   <= RESP_ERROR;
            resp_valid <= 1'b1;
            state      <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign args      = bank;
  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_cmd_decoder.sv
// tb_cmd_decoder: directed bench for cmd_decoder with a response scoreboard
// and a start-pulse scoreboard drained by a monitor on the falling edge.
module tb_cmd_decoder;

  localparam int DATA_W   = 8;
  localparam int MAX_ARGS = 3;
  localparam int TIMEOUT  = 32;
  localparam int N_SUB    = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DATA_W-1:0]          data = '0;
  logic                       data_ready = 1'b0;
  logic [N_SUB-1:0]           sub_done = '0;
  logic [N_SUB-1:0]           sub_err = '0;
  logic [N_SUB-1:0]           start;
  logic [MAX_ARGS*DATA_W-1:0] args;
  logic [7:0]                 response;
  logic                       resp_valid;
  logic                       busy;
  logic [1:0]                 state_dbg;

  cmd_decoder #(
    .DATA_W   (DATA_W),
    .MAX_ARGS (MAX_ARGS),
    .TIMEOUT  (TIMEOUT),
    .N_SUB    (N_SUB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data       (data),
    .data_ready (data_ready),
    .sub_done   (sub_done),
    .sub_err    (sub_err),
    .start      (start),
    .args       (args),
    .response   (response),
    .resp_valid (resp_valid),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [7:0]       exp_q[$];
  logic [N_SUB-1:0] exp_start_q[$];
  int n_resp = 0;
  int n_start = 0;
  int last_resp_cyc = 0;
  int last_start_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (resp_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL resp_extra: got 0x%0h expected no response", response);
          end else begin
            check("response", 32'(response), 32'(exp_q.pop_front()));
          end
          n_resp++;
          last_resp_cyc = cyc;
        end
        if (start != '0) begin
          if (exp_start_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL start_extra: got 0x%0h expected no start", start);
          end else begin
            check("start", 32'(start), 32'(exp_start_q.pop_front()));
          end
          n_start++;
          last_start_cyc = cyc;
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold, output int t_rise);
    step();
    data       = b;
    data_ready = 1'b1;
    t_rise     = cyc;
    repeat (hold) step();
    data_ready = 1'b0;
    repeat (4) step();
  endtask

  task automatic send(input logic [7:0] b);
    int t;
    send_byte(b, 3, t);
  endtask

  task automatic pulse(input logic [N_SUB-1:0] d, input logic [N_SUB-1:0] e, output int ts);
    step();
    sub_done = d;
    sub_err  = e;
    ts       = cyc;
    step();
    sub_done = '0;
    sub_err  = '0;
  endtask

  task automatic wait_resp(input int target, input string name);
    int b;
    b = 0;
    while (n_resp < target && b < 200) begin
      step();
      b++;
    end
    checks++;
    if (n_resp < target) begin
      errors++;
      $display("FAIL %s: got %0d responses expected %0d", name, n_resp, target);
    end
  endtask

  task automatic wait_start(input int target, input string name);
    int b;
    b = 0;
    while (n_start < target && b < 200) begin
      step();
      b++;
    end
    checks++;
    if (n_start < target) begin
      errors++;
      $display("FAIL %s: got %0d start pulses expected %0d", name, n_start, target);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int t;
    int ts;
    fork
      monitor();
    join_none

    // Reset state
    rst_n = 1'b0;
    repeat (3) step();
    check("rst_response", 32'(response), 32'h00);
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_args", 32'(args), 32'h0);
    check("rst_start", 32'(start), 32'h0);
    check("rst_state", 32'(state_dbg), 32'h0);
    rst_n = 1'b1;
    step();

    // PING: 3-cycle latency, no busy
    exp_q.push_back(8'h05);
    send_byte(8'h02, 3, t);
    wait_resp(1, "ping_wait");
    check("ping_latency", 32'(last_resp_cyc - t), 32'd3);
    check("ping_busy", 32'(busy), 32'h0);
    check("ping_args", 32'(args), 32'h0);

    // TOKEN with three args, done 5 cycles into WAIT
    exp_q.push_back(8'h04);
    send(8'h06);
    exp_start_q.push_back(4'b1000);
    send(8'h0A);
    send(8'h0B);
    send(8'h0C);
    wait_start(1, "token_start_wait");
    check("token_args", 32'(args), 32'h0C0B0A);
    check("token_busy", 32'(busy), 32'h1);
    repeat (5) step();
    exp_q.push_back(8'h03);
    pulse(4'b1000, 4'b0000, ts);
    wait_resp(3, "token_done_wait");
    check("done_latency", 32'(last_resp_cyc - ts), 32'd1);
    check("done_busy", 32'(busy), 32'h0);

    // CTRL aborted in ARGS by a 0x01 byte
    exp_q.push_back(8'h04);
    send(8'h03);
    send(8'h07);
    exp_q.push_back(8'h01);
    send(8'h01);
    wait_resp(5, "abort_wait");
    check("abort_args", 32'(args), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_no_start", 32'(n_start), 32'd1);

    // CTRL with simultaneous done and err on channel 0: err wins
    exp_q.push_back(8'h04);
    send(8'h03);
    exp_start_q.push_back(4'b0001);
    send(8'h07);
    send(8'h02);
    wait_start(2, "ctrl_start_wait");
    check("ctrl_args", 32'(args), 32'h000207);
    exp_q.push_back(8'h02);
    pulse(4'b0001, 4'b0001, ts);
    wait_resp(7, "ctrl_err_wait");
    check("ctrl_busy", 32'(busy), 32'h0);

    // SOUND with no strobe on its channel: timeout; done[2] ignored
    exp_q.push_back(8'h04);
    send(8'h04);
    exp_start_q.push_back(4'b0010);
    send(8'h05);
    wait_start(3, "sound_start_wait");
    check("sound_args", 32'(args), 32'h000005);
    repeat (3) step();
    pulse(4'b0100, 4'b0000, ts);
    check("sound_ignore_busy", 32'(busy), 32'h1);
    exp_q.push_back(8'h02);
    wait_resp(9, "timeout_wait");
    check("timeout_cycles", 32'(last_resp_cyc - last_start_cyc), 32'(TIMEOUT));

    // Unknown verb, then a long data_ready high accepts one byte only
    exp_q.push_back(8'h02);
    send(8'h09);
    wait_resp(10, "unknown_wait");
    exp_q.push_back(8'h05);
    send_byte(8'h02, 10, t);
    wait_resp(11, "long_hold_wait");
    repeat (10) step();
    check("long_hold_count", 32'(n_resp), 32'd11);

    // Reset during WAIT of a TOKEN command
    exp_q.push_back(8'h04);
    send(8'h06);
    exp_start_q.push_back(4'b1000);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    wait_start(4, "token2_start_wait");
    repeat (2) step();
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_args", 32'(args), 32'h0);
    check("midrst_response", 32'(response), 32'h0);
    check("midrst_resp_valid", 32'(resp_valid), 32'h0);
    check("midrst_start", 32'(start), 32'h0);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (TIMEOUT + 10) step();
    check("midrst_no_resp", 32'(n_resp), 32'd12);
    exp_q.push_back(8'h05);
    send(8'h02);
    wait_resp(13, "post_rst_ping_wait");

    repeat (5) step();
    check("resp_queue_empty", 32'(exp_q.size()), 32'd0);
    check("start_queue_empty", 32'(exp_start_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
